// File: rtl/ram_sp_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM, 3-cycle grant-to-read-data latency.
// Define RAM_ARB_FIXED_PRIO_EN to make port A always win contention instead of round-robin.
module ram_sp_arbiter #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  output logic [DWIDTH-1:0] b_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DWIDTH-1:0] ram_rdata
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  logic              grant_any;
  port_t             grant_port;
  logic              sel_we;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              s1_valid;
  logic              s2_valid;
  port_t             s1_owner;
  port_t             s2_owner;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      a_gnt = a_req;
      b_gnt = b_req && !a_req;
    end
  end
`else
  port_t ptr;

  // Pointer only matters under contention; it always moves to the port that lost or was idle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (a_req && b_req) begin
        a_gnt = (ptr == PORT_A);
        b_gnt = (ptr == PORT_B);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT_A;
    end else if (a_gnt) begin
      ptr <= PORT_B;
    end else if (b_gnt) begin
      ptr <= PORT_A;
    end
  end
`endif

  assign grant_any  = a_gnt | b_gnt;
  assign grant_port = b_gnt ? PORT_B : PORT_A;
  assign sel_we     = b_gnt ? b_we    : a_we;
  assign sel_addr   = b_gnt ? b_addr  : a_addr;
  assign sel_wdata  = b_gnt ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= grant_any && sel_we;
      ram_re <= grant_any && !sel_we;
      if (grant_any) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
      end
    end
  end

  // Owner tags follow each read through the RAM so returning data reaches the right port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_owner <= PORT_A;
      s2_owner <= PORT_A;
    end else begin
      s1_valid <= grant_any && !sel_we;
      s1_owner <= grant_port;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= s2_valid && (s2_owner == PORT_A);
      b_rvalid <= s2_valid && (s2_owner == PORT_B);
      if (s2_valid && (s2_owner == PORT_A)) begin
        a_rdata <= ram_rdata;
      end
      if (s2_valid && (s2_owner == PORT_B)) begin
        b_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: behavioural single-port RAM, grant vector table and read-data scoreboard.
module tb_ram_sp_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [8:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [8:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we, ram_re;
  logic [7:0] ram_rdata;

  typedef struct {
    logic       a_req;
    logic       a_we;
    logic [8:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_req;
    logic       b_we;
    logic [8:0] b_addr;
    logic [7:0] b_wdata;
    logic       exp_a;
    logic       exp_b;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } sb_t;

  sb_t        qa[$];
  sb_t        qb[$];
  logic [7:0] model [0:511];
  logic [7:0] mem   [0:511];
  logic       load_en;
  int         cyc;
  int         checks;
  int         errors;
  logic [7:0] last_a, last_b;
  vec_t       tbl [12];

  ram_sp_arbiter #(.AWIDTH(9), .DWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] initVal(input int i);
    if (i < 8) return 8'(8'h10 + i);
    return 8'(i * 7 + 3);
  endfunction

  // Behavioural RAM: read data appears the cycle after ram_re is sampled.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 512; i++) mem[i] <= initVal(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic ar, input logic aw, input logic [8:0] aa, input logic [7:0] ad,
                               input logic br, input logic bw, input logic [8:0] ba, input logic [7:0] bd,
                               input logic ea, input logic eb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  // Drives one cycle of requests, checks grants, and records the expected effect of each grant.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(posedge clk);
    #1;
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
    @(negedge clk);
    checkOutput("a_gnt", 32'(a_gnt), 32'(v.exp_a));
    checkOutput("b_gnt", 32'(b_gnt), 32'(v.exp_b));
    if (v.exp_a) begin
      if (v.a_we) model[v.a_addr] = v.a_wdata;
      else begin
        e.data = model[v.a_addr]; e.due = cyc + 3; qa.push_back(e);
      end
    end
    if (v.exp_b) begin
      if (v.b_we) model[v.b_addr] = v.b_wdata;
      else begin
        e.data = model[v.b_addr]; e.due = cyc + 3; qb.push_back(e);
      end
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_a_gnt", 32'(a_gnt), 0);
    checkOutput("rst_b_gnt", 32'(b_gnt), 0);
    checkOutput("rst_ram_we", 32'(ram_we), 0);
    checkOutput("rst_ram_re", 32'(ram_re), 0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 0);
    checkOutput("rst_a_rvalid", 32'(a_rvalid), 0);
    checkOutput("rst_b_rvalid", 32'(b_rvalid), 0);
    checkOutput("rst_a_rdata", 32'(a_rdata), 0);
    checkOutput("rst_b_rdata", 32'(b_rdata), 0);
  endtask

  // Holds both requests high through reset to confirm that no grant leaks out.
  task automatic doReset();
    @(posedge clk);
    #1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    #1;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (qa.size() + qb.size()) > 0; i++) @(negedge clk);
    checkOutput("sb_drain", 32'(qa.size() + qb.size()), 0);
  endtask

  // Read-return monitor: every rvalid must match the head of its port's queue on its due cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_a = 8'h00;
      last_b = 8'h00;
    end else begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        checkOutput("a_rvalid", 32'(a_rvalid), 1);
        checkOutput("a_rdata", 32'(a_rdata), 32'(qa[0].data));
        void'(qa.pop_front());
      end else begin
        checkOutput("a_rvalid_idle", 32'(a_rvalid), 0);
        checkOutput("a_rdata_hold", 32'(a_rdata), 32'(last_a));
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
        checkOutput("b_rvalid", 32'(b_rvalid), 1);
        checkOutput("b_rdata", 32'(b_rdata), 32'(qb[0].data));
        void'(qb.pop_front());
      end else begin
        checkOutput("b_rvalid_idle", 32'(b_rvalid), 0);
        checkOutput("b_rdata_hold", 32'(b_rdata), 32'(last_b));
      end
      last_a = a_rdata;
      last_b = b_rdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       ea;
    logic [8:0] aa, ba;
    int         ai, bi;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; load_en = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    for (int i = 0; i < 512; i++) model[i] = initVal(i);

    repeat (2) @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    load_en = 1'b0;
    rst_n = 1'b1;

    // Rows chosen so the pointer is at A whenever both request; identical in both builds.
    tbl[0]  = mkv(1, 1, 9'h1A0, 8'h5C, 0, 0, 9'h000, 8'h00, 1, 0);
    tbl[1]  = mkv(1, 0, 9'h1A0, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0);
    tbl[2]  = mkv(0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0);
    tbl[3]  = mkv(0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'hFF, 0, 1);
    tbl[4]  = mkv(1, 0, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0);
    tbl[5]  = mkv(0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h77, 0, 1);
    tbl[6]  = mkv(1, 0, 9'h020, 8'h00, 1, 0, 9'h1A0, 8'h00, 1, 0);
    tbl[7]  = mkv(0, 0, 9'h000, 8'h00, 1, 0, 9'h1A0, 8'h00, 0, 1);
    tbl[8]  = mkv(1, 1, 9'h030, 8'h3C, 1, 0, 9'h1FF, 8'h00, 1, 0);
    tbl[9]  = mkv(0, 0, 9'h000, 8'h00, 1, 0, 9'h1FF, 8'h00, 0, 1);
    tbl[10] = mkv(1, 0, 9'h030, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0);
    tbl[11] = mkv(0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(tbl[i]);
    drain();

    $display("[TB] contention from reset");
    doReset();
    ai = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      ea = 1'b1;
`else
      ea = (k % 2 == 0);
`endif
      aa = 9'h040 + 9'(2 * ai);
      ba = 9'h041 + 9'(2 * bi);
      applyStimulus(mkv(1, 0, aa, 8'h00, 1, 0, ba, 8'h00, ea, !ea));
      if (ea) ai++;
      else bi++;
    end
    applyStimulus(tbl[11]);
    drain();

    $display("[TB] back-to-back reads on port B");
    for (int i = 0; i < 8; i++) applyStimulus(mkv(0, 0, 9'h000, 8'h00, 1, 0, 9'(i), 8'h00, 0, 1));
    applyStimulus(tbl[11]);
    drain();

    $display("[TB] reset with a read in flight");
    applyStimulus(mkv(1, 0, 9'h1A0, 8'h00, 0, 0, 9'h000, 8'h00, 1, 0));
    doReset();
    applyStimulus(mkv(1, 0, 9'h1FF, 8'h00, 1, 0, 9'h020, 8'h00, 1, 0));
    applyStimulus(mkv(0, 0, 9'h000, 8'h00, 1, 0, 9'h020, 8'h00, 0, 1));
    applyStimulus(tbl[11]);
    drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 9, RAM address width.
REQ-002 SHALL have parameter DWIDTH, default 8, RAM data width.
REQ-003 SHALL have port clk, input, 1, single clock for all logic; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports a_req / b_req, input, 1, requester x has a pending access.
REQ-006 SHALL have ports a_we / b_we, input, 1, access is a write (1) or a read (0).
REQ-007 SHALL have ports a_addr / b_addr, input, AWIDTH, access address.
REQ-008 SHALL have ports a_wdata / b_wdata, input, DWIDTH, write data.
REQ-009 SHALL have ports a_gnt / b_gnt, output, 1, access accepted this cycle.
REQ-010 SHALL have ports a_rvalid / b_rvalid, output, 1, read data valid, one-cycle pulse.
REQ-011 SHALL have ports a_rdata / b_rdata, output, DWIDTH, registered read data.
REQ-012 SHALL have ports ram_addr (AWIDTH), ram_wdata (DWIDTH), ram_we (1), ram_re (1), all outputs, registered command to the single-port RAM.
REQ-013 SHALL have port ram_rdata, input, DWIDTH, RAM read data, valid one cycle after ram_re is sampled.

Function
REQ-014 SHALL compute x_gnt combinationally in cycle N from x_req and the priority pointer; at most one gnt high per cycle.
REQ-015 SHALL register the granted access onto ram_* at the end of cycle N; ram_we or ram_re is high for exactly one cycle (N+1); both low when nothing is granted.
REQ-016 SHALL hold ram_addr and ram_wdata at their last values when idle.
REQ-017 SHALL pulse x_rvalid in cycle N+3 for a read granted in cycle N, with x_rdata = ram_rdata captured at the end of N+2; 3-cycle grant-to-data latency.
REQ-018 SHALL generate no rvalid for writes; a write is committed at the end of cycle N+1.
REQ-019 SHALL sustain one grant per cycle; back-to-back reads SHALL produce back-to-back rvalid pulses routed to the correct requester through a 2-stage owner/valid pipeline.
REQ-020 SHALL grant the sole requester when only one req is high, regardless of the pointer.
REQ-021 SHALL grant the pointed-to port when both req are high; after every grant the pointer moves to the non-granted port.
REQ-022 SHALL require requester-side stability: req, we, addr, wdata held until gnt; the requester can drop req or present a new access in the cycle after gnt.
REQ-023 SHALL keep x_rdata unchanged except on x_rvalid.
REQ-024 SHALL ensure a read following a write to the same address returns the written data; this follows from the single command stream and needs no extra logic.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear ram_we, ram_re, ram_addr, ram_wdata, a/b_rvalid, a/b_rdata and the pipeline valid bits to 0, and set the pointer to port A.
REQ-026 SHALL assert no gnt while rst_n is low.
REQ-027 SHALL discard reads in flight at reset: no rvalid after rst_n deasserts.

Configuration
REQ-028 SHALL support macro RAM_ARB_FIXED_PRIO_EN; when defined, port A always wins contention and the pointer is removed; when undefined, round-robin per REQ-021 applies.

Verification
REQ-029 SHALL cover: a_req write addr 0x1A0 data 0x5C, then a_req read 0x1A0 -> a_rvalid 3 cycles after the read grant, a_rdata=0x5C.
REQ-030 SHALL cover: a_req and b_req both held for 4 reads from reset -> grants A,B,A,B (fixed-prio build: A,A,A,A); each rvalid goes to its own requester.
REQ-031 SHALL cover: b_req issues 8 back-to-back reads of 0x000-0x007 preloaded with 0x10-0x17 -> 8 consecutive b_rvalid cycles carrying 0x10-0x17 in order.
REQ-032 SHALL cover: rst_n pulsed low 1 cycle after a read grant -> no a_rvalid, all outputs 0, pointer at A.
REQ-033 SHALL cover: write 0x1FF/0xFF immediately followed by a read of 0x1FF from the other port -> rdata 0xFF (address wrap-edge case).
